dbus_sram_resp: RTL and testbench
=================================

DBUS_SRAM_RESP -- requirements
Module: dbus_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data store; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port dreq, input, dbus_req_t[1:0]: per-lane request fields valid, addr, size (MSIZE1/2/4), strobe[3:0], data[31:0]. Lane 1 is the older instruction; lane 0 is the younger.
REQ-005 SHALL have port dresp, output, dbus_resp_t[1:0]: per-lane response fields addr_ok, data_ok, data[31:0].
REQ-006 SHALL have port err, output, 2: per-lane misalignment flag, qualified by the matching data_ok.

Function
REQ-007 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so accesses wrap modulo the store size.
REQ-008 FSM states SHALL be IDLE, RESP1, RESP0.
REQ-009 In IDLE, if dreq[1].valid is set and lane 1 is not served, the block SHALL assert dresp[1].addr_ok, perform the access, and go to RESP1.
REQ-010 Otherwise in IDLE, if dreq[0].valid is set and lane 0 is not served, it SHALL assert dresp[0].addr_ok, perform the access, and go to RESP0.
REQ-011 In RESP1, dresp[1].data_ok SHALL be 1 for exactly one cycle and lane 1 SHALL be marked served. If lane 0 is valid and not served, the lane-0 access SHALL be accepted in the same cycle (addr_ok[0]=1) and the FSM SHALL go to RESP0; otherwise it SHALL go to IDLE.
REQ-012 In RESP0, dresp[0].data_ok SHALL be 1 for one cycle, lane 0 SHALL be marked served, and the FSM SHALL go to IDLE.
REQ-013 Latency: accept at cycle T, data_ok at T+1. A dual-lane pair accepted at cycle T completes with lane 1 data_ok at T+1 and lane 0 data_ok at T+2.
REQ-014 Access type: a lane with strobe == 0 is a read; a lane with strobe != 0 is a write.
REQ-015 Read: the full stored word SHALL be returned on data with data_ok; the initiator extracts bytes.
REQ-016 Write: byte k of data SHALL be written to the store when strobe[k]=1; the other bytes are unchanged. The store is updated at the acceptance edge. data on data_ok SHALL be the word before the write.
REQ-017 Ordering: a lane-0 access to the same word as a lane-1 write SHALL observe the lane-1 write.
REQ-018 Pair completion: served flags SHALL clear together once every lane that was valid at pair start has been served.
REQ-019 A lane's served flag SHALL also clear when its valid is low. The initiator holds valid and fields stable until data_ok and presents the next pair no earlier than the cycle after completion.
REQ-020 A lane whose valid drops before acceptance SHALL be neither accepted nor served. Dropping valid after acceptance SHALL not cancel the pending data_ok.
REQ-021 addr_ok and data_ok SHALL be 0 whenever not asserted by REQ-009 to REQ-012.
REQ-022 dresp.data and err SHALL be 0 when data_ok is 0.

Reset
REQ-023 On reset, the FSM SHALL go to IDLE and served flags SHALL clear.
REQ-024 On reset, all addr_ok, data_ok, data, and err outputs SHALL be 0 from the next edge.
REQ-025 Reset SHALL take effect mid-transaction, discarding any pending data_ok. A write accepted before reset remains committed.
REQ-026 Store contents SHALL not be reset.

Configuration
REQ-027 With DBUS_RESP_ALIGN_CHECK_EN defined, an access is misaligned when size is MSIZE2 and addr[0] != 0, or size is MSIZE4 and addr[1:0] != 0.
REQ-028 For a misaligned access (macro defined), the block SHALL perform no store update and respond with normal timing, err=1 and data=0.
REQ-029 Without DBUS_RESP_ALIGN_CHECK_EN, err SHALL be constantly 0, addr[1:0] SHALL be ignored, and the access SHALL follow strobe.

Verification
REQ-030 Scenario: single lane-1 write, addr 0x0000_0010, strobe 4'hF, data 0xDEADBEEF, then a read of the same address -> addr_ok at T, data_ok at T+1, read data 0xDEADBEEF.
REQ-031 Scenario: dual lanes, lane 1 writes 0x11223344 and lane 0 reads the same address -> data_ok[1] at T+1, data_ok[0] at T+2 with data 0x11223344.
REQ-032 Scenario: byte write strobe 4'b0100, data 0x00AB0000, onto a word holding 0x11223344 -> subsequent read returns 0x11AB3344.
REQ-033 Scenario: wrap-around with DEPTH_WORDS=1024, write to 0x0000_1000, read from 0x0000_0000 -> read returns the written word.
REQ-034 Scenario: reset asserted in RESP1 -> no data_ok next cycle, FSM in IDLE, the write is retained.
REQ-035 Scenario (macro defined): MSIZE4 write at 0x0000_0006 -> data_ok with err=1, and the store is unchanged on readback.

Source files
------------

// File: rtl/dbus_sram_resp.sv
// ---------------------------------------------------------------------------
// dbus_sram_resp -- two-lane data-bus responder backed by a word-wide SRAM.
//
// Purpose:
//   Serves a pair of data-bus requests (lane 1 = older, lane 0 = younger)
//   one at a time against an internal DEPTH_WORDS x 32-bit store. Each
//   access is accepted (addr_ok) in one cycle and answered (data_ok) in the
//   next. Lane 1 always goes first. When both lanes are valid, the lane-0
//   accept overlaps the lane-1 response.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the store (power of two, >= 4)
//
// Ports:
//   clk          the only clock, rising edge
//   reset        synchronous, active-high
//   dreq[1:0]    per-lane request: valid, addr, size, strobe, data
//   dresp[1:0]   per-lane response: addr_ok, data_ok, data
//   err[1:0]     per-lane misalignment flag, qualified by data_ok
//
// Build option:
//   DBUS_RESP_ALIGN_CHECK_EN  when defined, misaligned halfword/word
//                             accesses do not touch the store and are
//                             answered with err=1 and data=0. When it is
//                             undefined, err stays 0 and addr[1:0] is
//                             ignored.
// ---------------------------------------------------------------------------

package dbus_sram_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

module dbus_sram_resp
  import dbus_sram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t  [1:0] dreq,
  output dbus_resp_t [1:0] dresp,
  output logic       [1:0] err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    RESP1,
    RESP0
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       served_q, served_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [1:0]       acc;
  logic [1:0]       served_set;
  logic [1:0]       served_n;
  logic             pair_done;
  logic             acc_sel;
  dbus_req_t        acc_req;
  logic [AW-1:0]    acc_idx;
  logic [31:0]      old_word;
  logic [31:0]      new_word;
  logic             misaligned;
  logic             wr_en;
  logic             unused_bits;

  // Sequencer: lane 1 is accepted first. Its response cycle can also accept
  // lane 0, so a full pair takes three cycles (accept1, resp1+accept0,
  // resp0). Nothing is accepted while reset is high, so a request held
  // across reset is not written and does not produce a stray addr_ok.
  always_comb begin
    state_d    = state_q;
    acc        = '0;
    served_set = '0;
    case (state_q)
      IDLE: begin
        if (dreq[1].valid && !served_q[1]) begin
          acc[1]  = 1'b1;
          state_d = RESP1;
        end else if (dreq[0].valid && !served_q[0]) begin
          acc[0]  = 1'b1;
          state_d = RESP0;
        end
      end
      RESP1: begin
        served_set[1] = 1'b1;
        if (dreq[0].valid && !served_q[0]) begin
          acc[0]  = 1'b1;
          state_d = RESP0;
        end else begin
          state_d = IDLE;
        end
      end
      RESP0: begin
        served_set[0] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      acc = '0;
    end

    // A served flag only persists while its lane stays valid. Once every
    // valid lane has been served, the pair is complete and both flags clear
    // together. The next pair then starts with a clean slate.
    served_n  = (served_q | served_set) & {dreq[1].valid, dreq[0].valid};
    pair_done = (served_n[1] | ~dreq[1].valid) & (served_n[0] | ~dreq[0].valid);
    served_d  = pair_done ? 2'b00 : served_n;
  end

  // Datapath for the single access accepted this cycle. At most one lane is
  // accepted per cycle, so one read/write port is enough. The old word is
  // read from the array before the acceptance edge. That makes a write
  // return the pre-write value. A lane-0 access accepted one edge after a
  // lane-1 write sees the updated word.
  always_comb begin
    acc_sel  = acc[1];
    acc_req  = dreq[acc_sel];
    acc_idx  = acc_req.addr[AW+1:2];
    old_word = mem[acc_idx];
    new_word = old_word;
    for (int k = 0; k < 4; k++) begin
      if (acc_req.strobe[k]) begin
        new_word[8*k +: 8] = acc_req.data[8*k +: 8];
      end
    end
    wr_en   = (|acc) && (|acc_req.strobe) && !misaligned;
    rdata_d = rdata_q;
    if (|acc) begin
      rdata_d[acc_sel] = misaligned ? 32'h0 : old_word;
    end
  end

`ifdef DBUS_RESP_ALIGN_CHECK_EN
  logic [1:0] err_q, err_d;

  // Halfword accesses must be 2-byte aligned. Word accesses must be
  // 4-byte aligned. Byte accesses are never misaligned.
  always_comb begin
    misaligned = 1'b0;
    case (acc_req.size)
      MSIZE2:  misaligned = acc_req.addr[0];
      MSIZE4:  misaligned = |acc_req.addr[1:0];
      default: misaligned = 1'b0;
    endcase
    err_d = err_q;
    if (|acc) begin
      err_d[acc_sel] = misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    err    = '0;
    err[1] = dresp[1].data_ok & err_q[1];
    err[0] = dresp[0].data_ok & err_q[0];
  end

  assign unused_bits = ^{acc_req.valid, acc_req.addr[31:AW+2]};
`else
  assign misaligned  = 1'b0;
  assign err         = 2'b00;
  assign unused_bits = ^{acc_req.valid, acc_req.addr[31:AW+2],
                         acc_req.addr[1:0], acc_req.size};
`endif

  // Control and response registers. The store itself is not reset. A write
  // that was accepted before reset stays committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      served_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      rdata_q  <= rdata_d;
    end
  end

  // Store write port. This updates at the acceptance edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[acc_idx] <= new_word;
    end
  end

  // Response lanes. data is forced to zero outside data_ok, and everything
  // is held low while reset is asserted.
  always_comb begin
    dresp            = '0;
    dresp[1].addr_ok = acc[1];
    dresp[0].addr_ok = acc[0];
    if (!reset && state_q == RESP1) begin
      dresp[1].data_ok = 1'b1;
      dresp[1].data    = rdata_q[1];
    end
    if (!reset && state_q == RESP0) begin
      dresp[0].data_ok = 1'b1;
      dresp[0].data    = rdata_q[0];
    end
  end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// ---------------------------------------------------------------------------
// tb_dbus_sram_resp -- self-checking bench for dbus_sram_resp.
// A behavioural store model (plain array, byte-merge loop) predicts read
// data and err. Handshake timing is predicted from the lane pattern alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dbus_sram_resp;
  import dbus_sram_pkg::*;

  localparam int DEPTH = 1024;

  logic             clk = 1'b0;
  logic             reset;
  dbus_req_t  [1:0] dreq;
  dbus_resp_t [1:0] dresp;
  logic       [1:0] err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [DEPTH];

  // Per-pair observation, filled by run_pair.
  // trace nibble c = {addr_ok1, addr_ok0, data_ok1, data_ok0} in cycle c.
  logic [15:0] obs_trace;
  logic [31:0] obs_d1, obs_d0;
  logic [1:0]  obs_err;
  logic        obs_leak;

  dbus_sram_resp #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic dbus_req_t mk(logic v, logic [31:0] a, msize_t s,
                                   logic [3:0] st, logic [31:0] d);
    dbus_req_t r;
    r.valid  = v;
    r.addr   = a;
    r.size   = s;
    r.strobe = st;
    r.data   = d;
    return r;
  endfunction

  // Handshake timing depends only on which lanes are valid.
  function automatic logic [15:0] expected_trace(logic v1, logic v0);
    if (v1 && v0) return 16'h0168;
    if (v1)       return 16'h0028;
    if (v0)       return 16'h0014;
    return 16'h0000;
  endfunction

  // Store model: returns the word seen by the access, then applies the write.
  task automatic model_access(input dbus_req_t r, output logic [31:0] rd,
                              output logic e);
    int          idx;
    logic [31:0] w;
    idx = int'(r.addr / 4) % DEPTH;
    e   = 1'b0;
`ifdef DBUS_RESP_ALIGN_CHECK_EN
    if ((r.size == MSIZE2 && (r.addr % 2) != 0) ||
        (r.size == MSIZE4 && (r.addr % 4) != 0)) e = 1'b1;
`endif
    if (e) begin
      rd = 32'h0;
    end else begin
      rd = model_mem[idx];
      w  = model_mem[idx];
      for (int k = 0; k < 4; k++)
        if (r.strobe[k]) w[8*k +: 8] = r.data[8*k +: 8];
      model_mem[idx] = w;
    end
  endtask

  // Present a pair, hold it until its last data_ok, then drop it. Record
  // four cycles of handshakes plus captured data/err.
  task automatic run_pair(input dbus_req_t r1, input dbus_req_t r0);
    int ncyc;
    ncyc      = (r1.valid && r0.valid) ? 3 : 2;
    obs_trace = '0;
    obs_d1    = '0;
    obs_d0    = '0;
    obs_err   = '0;
    obs_leak  = 1'b0;
    @(negedge clk);
    dreq[1] = r1;
    dreq[0] = r0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c >= ncyc) dreq = '0;
      end
      #2;
      obs_trace[4*c +: 4] = {dresp[1].addr_ok, dresp[0].addr_ok,
                             dresp[1].data_ok, dresp[0].data_ok};
      if (dresp[1].data_ok) begin
        obs_d1     = dresp[1].data;
        obs_err[1] = err[1];
      end else if (dresp[1].data !== 32'h0 || err[1] !== 1'b0) begin
        obs_leak = 1'b1;
      end
      if (dresp[0].data_ok) begin
        obs_d0     = dresp[0].data;
        obs_err[0] = err[0];
      end else if (dresp[0].data !== 32'h0 || err[0] !== 1'b0) begin
        obs_leak = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    dreq    = '0;
    dreq[1] = mk(1'b1, 32'h8, MSIZE4, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (dresp !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dresp got %h want 0", dresp);
    end
    checks++;
    if (err !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_err got %b want 00", err);
    end
    @(negedge clk);
    reset = 1'b0;
    dreq  = '0;
    #2;
    checks++;
    if (dresp !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %h want 0", dresp);
    end
  endtask

  // Full-word writes to words 0..31 so later reads have known contents.
  task automatic test_fill();
    dbus_req_t   r1, r0;
    logic [31:0] rd;
    logic        e;
    for (int i = 0; i < 16; i++) begin
      r1 = mk(1'b1, 32'(i * 8),     MSIZE4, 4'hF, $urandom);
      r0 = mk(1'b1, 32'(i * 8 + 4), MSIZE4, 4'hF, $urandom);
      model_access(r1, rd, e);
      model_access(r0, rd, e);
      run_pair(r1, r0);
      checks++;
      if (obs_trace !== 16'h0168) begin
        errors++;
        $display("[TB] FAIL fill_trace got %h want 0168", obs_trace);
      end
    end
  endtask

  task automatic test_scenarios();
    dbus_req_t   r1, r0, none;
    logic [31:0] rd;
    logic        e;
    none = '0;
    // Single write then readback.
    r1 = mk(1'b1, 32'h10, MSIZE4, 4'hF, 32'hDEADBEEF);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_trace !== 16'h0028) begin
      errors++;
      $display("[TB] FAIL single_write_trace got %h want 0028", obs_trace);
    end
    r1 = mk(1'b1, 32'h10, MSIZE4, 4'h0, 32'h0);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_d1 !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL single_read got %h want deadbeef", obs_d1);
    end
    // Dual lane: lane-0 read observes lane-1 write.
    r1 = mk(1'b1, 32'h40, MSIZE4, 4'hF, 32'h11223344);
    r0 = mk(1'b1, 32'h40, MSIZE4, 4'h0, 32'h0);
    model_access(r1, rd, e);
    model_access(r0, rd, e);
    run_pair(r1, r0);
    checks++;
    if (obs_trace !== 16'h0168) begin
      errors++;
      $display("[TB] FAIL dual_trace got %h want 0168", obs_trace);
    end
    checks++;
    if (obs_d0 !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL dual_forward got %h want 11223344", obs_d0);
    end
    // Byte write of lane 2 only.
    r1 = mk(1'b1, 32'h40, MSIZE1, 4'b0100, 32'h00AB0000);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_d1 !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL write_old_word got %h want 11223344", obs_d1);
    end
    r0 = mk(1'b1, 32'h40, MSIZE4, 4'h0, 32'h0);
    model_access(r0, rd, e);
    run_pair(none, r0);
    checks++;
    if (obs_trace !== 16'h0014) begin
      errors++;
      $display("[TB] FAIL lane0_trace got %h want 0014", obs_trace);
    end
    checks++;
    if (obs_d0 !== 32'h11AB3344) begin
      errors++;
      $display("[TB] FAIL byte_write got %h want 11ab3344", obs_d0);
    end
    // Wrap-around: 0x1000 aliases word 0.
    r1 = mk(1'b1, 32'h1000, MSIZE4, 4'hF, 32'hCAFEF00D);
    model_access(r1, rd, e);
    run_pair(r1, none);
    r1 = mk(1'b1, 32'h0, MSIZE4, 4'h0, 32'h0);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_d1 !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL wrap_read got %h want cafef00d", obs_d1);
    end
  endtask

  task automatic test_reset_mid();
    dbus_req_t   r1, none;
    logic [31:0] rd;
    logic        e;
    none = '0;
    r1   = mk(1'b1, 32'h80, MSIZE4, 4'hF, 32'h5A5A1234);
    model_access(r1, rd, e);
    @(negedge clk);
    dreq[1] = r1;
    dreq[0] = '0;
    #2;
    checks++;
    if (dresp[1].addr_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_accept got %b want 1", dresp[1].addr_ok);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (dresp !== '0 || err !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midreset_no_dataok got %h/%b want 0/00", dresp, err);
    end
    @(negedge clk);
    reset = 1'b0;
    dreq  = '0;
    r1    = mk(1'b1, 32'h80, MSIZE4, 4'h0, 32'h0);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_trace !== 16'h0028 || obs_d1 !== 32'h5A5A1234) begin
      errors++;
      $display("[TB] FAIL midreset_retained got %h/%h want 0028/5a5a1234",
               obs_trace, obs_d1);
    end
  endtask

  // Lane 0 drops valid before it is accepted: it must never be accepted.
  task automatic test_valid_drop();
    dbus_req_t   r1, r0;
    logic [31:0] exp1;
    logic        e;
    r1 = mk(1'b1, 32'h14, MSIZE4, 4'hF, $urandom);
    r0 = mk(1'b1, 32'h18, MSIZE4, 4'hF, $urandom);
    model_access(r1, exp1, e);
    @(negedge clk);
    dreq[1] = r1;
    dreq[0] = r0;
    #2;
    checks++;
    if ({dresp[1].addr_ok, dresp[0].addr_ok} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL drop_accept got %b want 10",
               {dresp[1].addr_ok, dresp[0].addr_ok});
    end
    @(negedge clk);
    dreq[0].valid = 1'b0;
    #2;
    checks++;
    if (dresp[1].data_ok !== 1'b1 || dresp[0].addr_ok !== 1'b0 ||
        dresp[1].data !== exp1) begin
      errors++;
      $display("[TB] FAIL drop_resp1 got %h want data_ok1 data %h", dresp, exp1);
    end
    @(negedge clk);
    dreq = '0;
    #2;
    checks++;
    if (dresp !== '0) begin
      errors++;
      $display("[TB] FAIL drop_no_lane0 got %h want 0", dresp);
    end
  endtask

  task automatic test_random();
    dbus_req_t   r1, r0;
    logic [31:0] exp1, exp0, a;
    logic        e1, e0;
    for (int n = 0; n < 60; n++) begin
      a  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2) |
           32'($urandom_range(0, 3));
      r1 = mk(1'($urandom_range(0, 1)), a, msize_t'($urandom_range(0, 2)),
              ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom);
      a  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 31)) << 2) |
           32'($urandom_range(0, 3));
      r0 = mk(1'($urandom_range(0, 1)), a, msize_t'($urandom_range(0, 2)),
              ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), $urandom);
      exp1 = '0; exp0 = '0; e1 = 1'b0; e0 = 1'b0;
      if (r1.valid) model_access(r1, exp1, e1);
      if (r0.valid) model_access(r0, exp0, e0);
      run_pair(r1, r0);
      checks++;
      if (obs_trace !== expected_trace(r1.valid, r0.valid)) begin
        errors++;
        $display("[TB] FAIL rand_trace[%0d] got %h want %h", n, obs_trace,
                 expected_trace(r1.valid, r0.valid));
      end
      checks++;
      if (obs_d1 !== exp1 || obs_d0 !== exp0) begin
        errors++;
        $display("[TB] FAIL rand_data[%0d] got %h/%h want %h/%h", n,
                 obs_d1, obs_d0, exp1, exp0);
      end
      checks++;
      if (obs_err !== {e1, e0}) begin
        errors++;
        $display("[TB] FAIL rand_err[%0d] got %b want %b", n, obs_err, {e1, e0});
      end
      checks++;
      if (obs_leak !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_idle_zero[%0d] got 1 want 0", n);
      end
    end
  endtask

`ifdef DBUS_RESP_ALIGN_CHECK_EN
  task automatic test_misalign();
    dbus_req_t   r1, none;
    logic [31:0] rd;
    logic        e;
    none = '0;
    r1   = mk(1'b1, 32'h4, MSIZE4, 4'hF, 32'h01020304);
    model_access(r1, rd, e);
    run_pair(r1, none);
    r1 = mk(1'b1, 32'h6, MSIZE4, 4'hF, 32'hFFFFFFFF);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_trace !== 16'h0028 || obs_err !== 2'b10 || obs_d1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL misalign_resp got %h/%b/%h want 0028/10/0",
               obs_trace, obs_err, obs_d1);
    end
    r1 = mk(1'b1, 32'h4, MSIZE4, 4'h0, 32'h0);
    model_access(r1, rd, e);
    run_pair(r1, none);
    checks++;
    if (obs_d1 !== 32'h01020304) begin
      errors++;
      $display("[TB] FAIL misalign_unchanged got %h want 01020304", obs_d1);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    dreq  = '0;
    test_reset();
    test_fill();
    test_scenarios();
    test_reset_mid();
    test_valid_drop();
`ifdef DBUS_RESP_ALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
